// File: rtl/opb_register_simulink2ppc.sv
// OPB slave readback register: captures a fabric word on a valid strobe and exposes
// DATA / STATUS / CONTROL to the PowerPC. Optional update counter: S2P_UPDATE_COUNT_EN.
module opb_register_simulink2ppc #(
   parameter logic [31:0] C_BASEADDR   = 32'h01000600,
   parameter logic [31:0] C_HIGHADDR   = 32'h010006FF,
   parameter int unsigned C_OPB_AWIDTH = 32,
   parameter int unsigned C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5"
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
   input  logic                        OPB_RNW,
   input  logic                        OPB_select,
   input  logic                        OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
   output logic                        Sl_xferAck,
   output logic                        Sl_errAck,
   output logic                        Sl_retry,
   output logic                        Sl_toutSup,
   input  logic [31:0]                 user_data_in,
   input  logic                        user_data_valid
);

   localparam logic [1:0] IDX_DATA    = 2'd0;
   localparam logic [1:0] IDX_STATUS  = 2'd1;
   localparam logic [1:0] IDX_CONTROL = 2'd2;
   localparam int unused_family_bits  = $bits(C_FAMILY);

   logic        r_ack;
   logic [31:0] r_dbus;
   logic [31:0] r_data;
   logic        r_new;
   logic        r_ovf;
   logic        r_freeze;
   logic [15:0] w_count;

   logic        w_hit;
   logic        w_accept;
   logic [1:0]  w_idx;
   logic        w_data_rd;
   logic        w_ctrl_wr;
   logic        w_clear;
   logic        w_capture;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_unused   = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29]};

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign Sl_xferAck = r_ack;
   assign Sl_DBus    = r_dbus;

   // Address decode and per-transfer strobes; a transfer is accepted on the edge that raises the ack.
   always_comb begin
      w_hit     = 1'b0;
      w_accept  = 1'b0;
      w_idx     = OPB_ABus[28:29];
      w_data_rd = 1'b0;
      w_ctrl_wr = 1'b0;
      w_clear   = 1'b0;
      w_capture = 1'b0;
      if (OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR)) begin
         w_hit = 1'b1;
      end else begin
         w_hit = 1'b0;
      end
      w_accept  = w_hit & ~r_ack;
      w_data_rd = w_accept & OPB_RNW & (w_idx == IDX_DATA);
      if (w_accept && !OPB_RNW && (w_idx == IDX_CONTROL) && OPB_BE[3]) begin
         w_ctrl_wr = 1'b1;
      end else begin
         w_ctrl_wr = 1'b0;
      end
      w_clear   = w_ctrl_wr & OPB_DBus[31];
      w_capture = user_data_valid & ~r_freeze;
   end

   // Read-data multiplexer over the current register state.
   always_comb begin
      w_rdata = 32'h0000_0000;
      case (w_idx)
         IDX_DATA:    w_rdata = r_data;
         IDX_STATUS:  w_rdata = {r_new, r_ovf, 14'd0, w_count};
         IDX_CONTROL: w_rdata = {30'd0, r_freeze, 1'b0};
         default:     w_rdata = 32'h0000_0000;
      endcase
   end

   // Bus response: single-cycle ack, read data driven only during the ack cycle.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         r_ack  <= 1'b0;
         r_dbus <= 32'h0000_0000;
      end else begin
         r_ack  <= w_accept;
         if (w_accept && OPB_RNW) begin
            r_dbus <= w_rdata;
         end else begin
            r_dbus <= 32'h0000_0000;
         end
      end
   end

   // Captured word and freeze control.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         r_data   <= 32'h0000_0000;
         r_freeze <= 1'b0;
      end else begin
         if (w_capture) begin
            r_data <= user_data_in;
         end else begin
            r_data <= r_data;
         end
         if (w_ctrl_wr) begin
            r_freeze <= OPB_DBus[30];
         end else begin
            r_freeze <= r_freeze;
         end
      end
   end

   // New/overflow flags: a capture wins over a coincident DATA read, and clear wins over overflow.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         r_new <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (w_capture) begin
            r_new <= 1'b1;
         end else if (w_data_rd) begin
            r_new <= 1'b0;
         end else begin
            r_new <= r_new;
         end
         if (w_clear) begin
            r_ovf <= 1'b0;
         end else if (w_capture && r_new && !w_data_rd) begin
            r_ovf <= 1'b1;
         end else begin
            r_ovf <= r_ovf;
         end
      end
   end

`ifdef S2P_UPDATE_COUNT_EN
   logic [15:0] r_count;

   assign w_count = r_count;

   // Update counter; clear with a coincident capture leaves one counted update.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         r_count <= 16'h0000;
      end else begin
         if (w_clear) begin
            r_count <= w_capture ? 16'h0001 : 16'h0000;
         end else if (w_capture) begin
            r_count <= r_count + 16'h0001;
         end else begin
            r_count <= r_count;
         end
      end
   end
`else
   assign w_count = 16'h0000;
`endif

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed, table-driven bench for opb_register_simulink2ppc; expectations track S2P_UPDATE_COUNT_EN.
module tb_opb_register_simulink2ppc;

   localparam logic [31:0] BASE = 32'h01000600;
   localparam logic [31:0] HIGH = 32'h010006FF;
`ifdef S2P_UPDATE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [0:31] abus;
   logic [0:3]  be;
   logic [0:31] dbus;
   logic        rnw, sel, seqaddr;
   logic [0:31] sl_dbus;
   logic        ack, errack, retry, toutsup;
   logic [31:0] udata;
   logic        uvalid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   opb_register_simulink2ppc dut (
      .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqaddr), .Sl_DBus(sl_dbus),
      .Sl_xferAck(ack), .Sl_errAck(errack), .Sl_retry(retry), .Sl_toutSup(toutsup),
      .user_data_in(udata), .user_data_valid(uvalid)
   );

   typedef struct {
      int          op;     // 0 read, 1 write, 2 valid strobe
      int          idx;
      logic [31:0] wd;
      logic [3:0]  bev;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] st(input bit n, input bit o, input int c);
      logic [31:0] cv;
      cv = c;
      return {n, o, 14'd0, (CNT_EN ? cv[15:0] : 16'd0)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic add(input int op, input int idx, input logic [31:0] wd, input logic [3:0] bev,
                      input logic [31:0] exp, input string nm);
      vec_t v;
      v.op = op; v.idx = idx; v.wd = wd; v.bev = bev; v.exp = exp; v.name = nm;
      vecs.push_back(v);
   endtask

   // One OPB transfer, bounded wait for ack, followed by one idle cycle.
   task automatic bus(input bit r, input int idx, input logic [31:0] wd, input logic [3:0] bev,
                      output logic [31:0] rd);
      bit got;
      got  = 1'b0;
      rd   = 32'hxxxx_xxxx;
      abus = BASE + 32'(idx * 4);
      rnw  = r; dbus = wd; be = bev; sel = 1'b1;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            got = 1'b1;
            rd  = sl_dbus;
         end
      end
      sel = 1'b0; rnw = 1'b0; dbus = 32'h0; be = 4'h0;
      if (!got) begin
         total++; bad++;
         $display("FAIL ack_timeout idx=%0d: got no ack expected ack", idx);
      end
      @(posedge clk); #1;
   endtask

   task automatic pulse(input logic [31:0] d);
      udata = d; uvalid = 1'b1;
      @(posedge clk); #1;
      uvalid = 1'b0;
   endtask

   task automatic count_acks(input logic [31:0] addr, input int cycles, output int n);
      n = 0;
      abus = addr; rnw = 1'b1; sel = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (ack) n++;
      end
      sel = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      int          n;
      int          dbad;

      rst_n = 1'b0; abus = 32'h0; be = 4'h0; dbus = 32'h0; rnw = 1'b0; sel = 1'b0;
      seqaddr = 1'b0; udata = 32'h0; uvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack", {31'd0, ack}, 32'h0);
      chk("reset_dbus", sl_dbus, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      add(0, 1, 32'h0, 4'hF, 32'h0000_0000, "rst_status");
      add(0, 0, 32'h0, 4'hF, 32'h0000_0000, "rst_data");
      add(2, 0, 32'hDEAD_BEEF, 4'hF, 32'h0, "");
      add(0, 1, 32'h0, 4'hF, st(1, 0, 1), "cap_status");
      add(0, 0, 32'h0, 4'hF, 32'hDEAD_BEEF, "cap_data");
      add(0, 1, 32'h0, 4'hF, st(0, 0, 1), "cap_status_after_read");
      add(2, 0, 32'h0000_0001, 4'hF, 32'h0, "");
      add(2, 0, 32'h0000_0002, 4'hF, 32'h0, "");
      add(0, 1, 32'h0, 4'hF, st(1, 1, 3), "ovf_status");
      add(1, 2, 32'h0000_0001, 4'hF, 32'h0, "");
      add(0, 1, 32'h0, 4'hF, st(1, 0, 0), "clear_status");
      add(0, 0, 32'h0, 4'hF, 32'h0000_0002, "ovf_data");
      add(0, 1, 32'h0, 4'hF, st(0, 0, 0), "status_after_clear_read");
      add(1, 2, 32'h0000_0002, 4'hF, 32'h0, "");
      for (int i = 0; i < 5; i++) add(2, 0, 32'hAAAA_0000 + 32'(i), 4'hF, 32'h0, "");
      add(0, 2, 32'h0, 4'hF, 32'h0000_0002, "freeze_ctrl");
      add(0, 0, 32'h0, 4'hF, 32'h0000_0002, "freeze_data");
      add(0, 1, 32'h0, 4'hF, st(0, 0, 0), "freeze_status");
      add(1, 2, 32'h0000_0000, 4'hF, 32'h0, "");
      add(2, 0, 32'h0000_0077, 4'hF, 32'h0, "");
      add(0, 1, 32'h0, 4'hF, st(1, 0, 1), "unfreeze_status");
      add(1, 2, 32'h0000_0002, 4'hE, 32'h0, "");
      add(0, 2, 32'h0, 4'hF, 32'h0000_0000, "be_freeze_ctrl");
      add(1, 2, 32'h0000_0001, 4'hE, 32'h0, "");
      add(0, 1, 32'h0, 4'hF, st(1, 0, 1), "be_clear_status");
      add(1, 0, 32'h1234_5678, 4'hF, 32'h0, "");
      add(0, 0, 32'h0, 4'hF, 32'h0000_0077, "data_write_ignored");
      add(1, 3, 32'hFFFF_FFFF, 4'hF, 32'h0, "");
      add(0, 3, 32'h0, 4'hF, 32'h0000_0000, "word3_read");
      add(0, 1, 32'h0, 4'hF, st(0, 0, 1), "status_end_table");

      foreach (vecs[k]) begin
         case (vecs[k].op)
            0: begin
               bus(1'b1, vecs[k].idx, 32'h0, vecs[k].bev, rd);
               chk(vecs[k].name, rd, vecs[k].exp);
            end
            1: bus(1'b0, vecs[k].idx, vecs[k].wd, vecs[k].bev, rd);
            default: pulse(vecs[k].wd);
         endcase
      end

      // capture coinciding with the DATA read ack
      pulse(32'h0000_0044);
      @(posedge clk); #1;
      abus = BASE; rnw = 1'b1; sel = 1'b1; udata = 32'h0000_0055; uvalid = 1'b1;
      @(posedge clk); #1;
      chk("same_cycle_ack", {31'd0, ack}, 32'h1);
      chk("same_cycle_rdata", sl_dbus, 32'h0000_0044);
      sel = 1'b0; uvalid = 1'b0;
      @(posedge clk); #1;
      bus(1'b1, 1, 32'h0, 4'hF, rd);
      chk("same_cycle_status", rd, st(1, 0, 3));
      bus(1'b1, 0, 32'h0, 4'hF, rd);
      chk("same_cycle_data", rd, 32'h0000_0055);

      // clear coinciding with a capture
      pulse(32'h1);
      pulse(32'h2);
      abus = BASE + 32'd8; rnw = 1'b0; dbus = 32'h1; be = 4'hF; sel = 1'b1;
      udata = 32'h0000_0099; uvalid = 1'b1;
      @(posedge clk); #1;
      chk("clear_cap_ack", {31'd0, ack}, 32'h1);
      sel = 1'b0; uvalid = 1'b0; dbus = 32'h0;
      @(posedge clk); #1;
      bus(1'b1, 1, 32'h0, 4'hF, rd);
      chk("clear_cap_status", rd, st(1, 0, 1));
      bus(1'b1, 0, 32'h0, 4'hF, rd);
      chk("clear_cap_data", rd, 32'h0000_0099);

      // select held for six cycles
      dbad = 0; n = 0;
      abus = BASE; rnw = 1'b1; sel = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            n++;
            if (sl_dbus !== 32'h0000_0099) dbad++;
         end else if (sl_dbus !== 32'h0) begin
            dbad++;
         end
      end
      sel = 1'b0;
      @(posedge clk); #1;
      chk("held_select_acks", n, 32'd3);
      chk("held_select_dbus_errors", dbad, 32'd0);

      count_acks(HIGH + 32'd5 - 32'd1, 3, n);
      chk("above_window_acks", n, 32'd0);
      count_acks(BASE - 32'd4, 3, n);
      chk("below_window_acks", n, 32'd0);

      // counter wrap
      bus(1'b0, 2, 32'h1, 4'hF, rd);
      udata = 32'hCAFE_0000; uvalid = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      uvalid = 1'b0;
      bus(1'b1, 1, 32'h0, 4'hF, rd);
      chk("wrap_status_ffff", rd, st(1, 1, 16'hFFFF));
      pulse(32'hCAFE_0001);
      bus(1'b1, 1, 32'h0, 4'hF, rd);
      chk("wrap_status_0000", rd, st(1, 1, 0));

      // reset during a transfer
      bus(1'b0, 2, 32'h2, 4'hF, rd);
      abus = BASE + 32'd4; rnw = 1'b1; sel = 1'b1;
      @(posedge clk); #1;
      chk("pre_reset_ack", {31'd0, ack}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_ack", {31'd0, ack}, 32'h0);
      chk("async_reset_dbus", sl_dbus, 32'h0);
      sel = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      bus(1'b1, 1, 32'h0, 4'hF, rd);
      chk("post_reset_status", rd, 32'h0);
      bus(1'b1, 0, 32'h0, 4'hF, rd);
      chk("post_reset_data", rd, 32'h0);
      bus(1'b1, 2, 32'h0, 4'hF, rd);
      chk("post_reset_ctrl", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
